// File: rtl/ir_period_tracker.sv
// IR index front end: synchroniser, debouncer, edge qualifier and rotation period tracker.
// Build option: define PERIOD_AVG_EN to report an exponential average on period_out instead of the raw period.
module ir_period_tracker #(
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int PERIOD_WIDTH    = 24,
    parameter int MIN_PERIOD      = 120000,
    parameter int MAX_PERIOD      = 12000000,
    parameter int LOCK_COUNT      = 3,
    parameter int AVG_SHIFT       = 2
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    ir_tripped,
    output logic                    index_pulse,
    output logic [PERIOD_WIDTH-1:0] period_out,
    output logic                    period_valid,
    output logic                    spinning,
    output logic                    stalled
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_COUNT);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [1:0]              sync_q;
    logic [DW-1:0]           db_cnt_q, db_cnt_d;
    logic                    db_lvl_q, db_lvl_d;
    logic                    db_prev_q;
    logic                    cand;

    logic [1:0]              state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic [GW-1:0]           good_q, good_d, good_inc;
    logic [PERIOD_WIDTH-1:0] per_q, per_d, per_next;
    logic                    pulse_q, pulse_d;
    logic                    pv_q, pv_d;
    logic                    spin_q, spin_d;
    logic                    stall_q, stall_d;
    logic                    timeout;

    // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d = '0;
        db_lvl_d = db_lvl_q;
        if (sync_q[1] != db_lvl_q) begin
            if (db_cnt_q == DB_LAST) db_lvl_d = ~db_lvl_q;
            else                     db_cnt_d = db_cnt_q + DW'(1);
        end
    end

    assign cand     = db_lvl_q & ~db_prev_q;
    assign timeout  = (cnt_q >= MAX_P);
    assign good_inc = good_q + GW'(1);

`ifdef PERIOD_AVG_EN
    logic signed [PERIOD_WIDTH:0] avg_diff, avg_sum;
    always_comb begin
        avg_diff = $signed({1'b0, cnt_q}) - $signed({1'b0, per_q});
        avg_sum  = $signed({1'b0, per_q}) + (avg_diff >>> AVG_SHIFT);
        // good_q is zero exactly for the first period after leaving IDLE
        per_next = (good_q == '0) ? cnt_q : avg_sum[PERIOD_WIDTH-1:0];
    end
`else
    logic unused_avg_cfg;
    assign unused_avg_cfg = (AVG_SHIFT != 0);
    assign per_next = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q < MAX_P) ? cnt_q + PERIOD_WIDTH'(1) : cnt_q;
        good_d  = good_q;
        per_d   = per_q;
        pulse_d = 1'b0;
        pv_d    = 1'b0;
        spin_d  = spin_q;
        stall_d = stall_q;
        case (state_q)
            S_IDLE: begin
                if (cand) begin
                    pulse_d = 1'b1;
                    cnt_d   = PERIOD_WIDTH'(1);
                    stall_d = 1'b0;
                    state_d = S_ARMED;
                end
            end
            S_ARMED, S_LOCKED: begin
                stall_d = 1'b0;
                if (timeout) begin
                    // Stall wins; a coincident edge restarts as a fresh first edge.
                    state_d = S_IDLE;
                    spin_d  = 1'b0;
                    stall_d = 1'b1;
                    good_d  = '0;
                    if (cand) begin
                        pulse_d = 1'b1;
                        cnt_d   = PERIOD_WIDTH'(1);
                        state_d = S_ARMED;
                    end
                end else if (cand && cnt_q >= MIN_P) begin
                    pulse_d = 1'b1;
                    pv_d    = 1'b1;
                    cnt_d   = PERIOD_WIDTH'(1);
                    per_d   = per_next;
                    if (state_q == S_ARMED) begin
                        good_d = good_inc;
                        if (good_inc == GOOD_LOCK) begin
                            state_d = S_LOCKED;
                            spin_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            db_lvl_q  <= 1'b0;
            db_prev_q <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            good_q    <= '0;
            per_q     <= '0;
            pulse_q   <= 1'b0;
            pv_q      <= 1'b0;
            spin_q    <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], ir_tripped};
            db_cnt_q  <= db_cnt_d;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            per_q     <= per_d;
            pulse_q   <= pulse_d;
            pv_q      <= pv_d;
            spin_q    <= spin_d;
            stall_q   <= stall_d;
        end
    end

    assign index_pulse  = pulse_q;
    assign period_out   = per_q;
    assign period_valid = pv_q;
    assign spinning     = spin_q;
    assign stalled      = stall_q;

endmodule

// File: tb/tb_ir_period_tracker.sv
// Scoreboard bench for ir_period_tracker: stimulus queues expected pulses, a monitor checks them.
module tb_ir_period_tracker;
    localparam int DEB = 4;
    localparam int PW  = 24;
    localparam int LAT = DEB + 3;  // drive at negedge k -> pulse visible at negedge k+DEB+3

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          ir_tripped = 1'b0;
    logic          index_pulse, period_valid, spinning, stalled;
    logic [PW-1:0] period_out;

    ir_period_tracker #(
        .DEBOUNCE_CYCLES(DEB), .PERIOD_WIDTH(PW), .MIN_PERIOD(100),
        .MAX_PERIOD(1000), .LOCK_COUNT(3), .AVG_SHIFT(2)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ir_tripped(ir_tripped),
        .index_pulse(index_pulse), .period_out(period_out),
        .period_valid(period_valid), .spinning(spinning), .stalled(stalled)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct { int cyc; bit pv; int per; bit spin; bit stl; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t5;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Raise the input for `width` cycles; returns `gap` cycles after the rise.
    task automatic fire(input int gap, input int width, input bit exp_on,
                        input bit pv, input int per, input bit spin, input bit stl);
        exp_t e;
        ir_tripped = 1'b1;
        if (exp_on) begin
            e.cyc = cyc + LAT; e.pv = pv; e.per = per; e.spin = spin; e.stl = stl;
            exp_q.push_back(e);
        end
        repeat (width) @(negedge clk_in);
        ir_tripped = 1'b0;
        repeat (gap - width) @(negedge clk_in);
    endtask

    initial forever begin
        @(negedge clk_in);
        if (!rst_in && (index_pulse || period_valid)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {index_pulse, period_valid}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pulse_cycle", cyc, mon_e.cyc);
                chk("index_pulse", index_pulse, 1);
                chk("period_valid", period_valid, mon_e.pv);
                if (mon_e.pv) chk("period_out", period_out, mon_e.per);
                chk("spinning", spinning, mon_e.spin);
                chk("stalled", stalled, mon_e.stl);
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_index_pulse", index_pulse, 0);
        chk("rst_period_valid", period_valid, 0);
        chk("rst_period_out", period_out, 0);
        chk("rst_spinning", spinning, 0);
        chk("rst_stalled", stalled, 0);
        rst_in = 1'b0;
        repeat (6) @(negedge clk_in);

        // first edge: pulse only, then a 3-cycle glitch that must vanish
        fire(100, 50, 1, 0, 0, 0, 0);
        ir_tripped = 1'b1;
        repeat (3) @(negedge clk_in);
        ir_tripped = 1'b0;
        repeat (397) @(negedge clk_in);
        chk("glitch_period_out", period_out, 0);
        chk("glitch_spinning", spinning, 0);

        // lock on 500-cycle edges, with a too-early extra edge after lock
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(50, 20, 1, 1, 500, 1, 0);
        fire(450, 20, 0, 0, 0, 0, 0);
        t5 = cyc;
        fire(20, 20, 1, 1, 500, 1, 0);

        // stall exactly MAX_PERIOD cycles after the last accepted edge
        while (cyc < t5 + LAT + 999) @(negedge clk_in);
        chk("pre_stall_stalled", stalled, 0);
        chk("pre_stall_spinning", spinning, 1);
        @(negedge clk_in);
        chk("stall_stalled", stalled, 1);
        chk("stall_spinning", spinning, 0);
        chk("stall_period_out", period_out, 500);
        repeat (50) @(negedge clk_in);
        fire(500, 20, 1, 0, 0, 0, 0);
        chk("post_stall_period_out", period_out, 500);
        chk("post_stall_stalled", stalled, 0);

        // relock, then asynchronous reset between clock edges
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(300, 20, 1, 1, 500, 1, 0);
        chk("pre_reset_spinning", spinning, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("async_rst_spinning", spinning, 0);
        chk("async_rst_period_out", period_out, 0);
        chk("async_rst_stalled", stalled, 0);
        chk("async_rst_index_pulse", index_pulse, 0);
        chk("async_rst_period_valid", period_valid, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        repeat (4) @(negedge clk_in);

        // four edges needed to re-lock, then MIN/MAX boundaries
        fire(500, 20, 1, 0, 0, 0, 0);
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(500, 20, 1, 1, 500, 0, 0);
        fire(100, 20, 1, 1, 500, 1, 0);
        fire(99, 20, 1, 1, 100, 1, 0);
        fire(900, 20, 0, 0, 0, 0, 0);
        fire(1000, 20, 1, 1, 999, 1, 0);
        fire(20, 20, 1, 0, 0, 0, 1);
        chk("coincident_stalled_cleared", stalled, 0);
        chk("coincident_period_out", period_out, 999);
        chk("coincident_spinning", spinning, 0);

        repeat (20) @(negedge clk_in);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
